// File: rtl/counter_increment_sched.sv
// Involuntary counter increment scheduler: gathers +1/-1 requests per counter cell, parks the
// sequencer at an instruction boundary and read-modify-writes the counter words in memory.
module counter_increment_sched #(
  parameter int unsigned N_CNT        = 8,
  parameter int unsigned AW           = 12,
  parameter int unsigned DW           = 16,
  parameter int unsigned BASE_ADDR    = 20,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned MAX_PER_SLOT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CNT-1:0] inc_req,
  input  logic [N_CNT-1:0] dec_req,
  input  logic             slot_ok,
  output logic             hold,
  output logic             mem_req,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_rdata,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_wr,
  output logic [N_CNT-1:0] ovf,
  output logic             drop
);

  localparam int unsigned IdxW = (N_CNT > 1) ? $clog2(N_CNT) : 1;
  localparam int unsigned LatW = $clog2(MEM_LAT + 1);
  localparam int unsigned SrvW = $clog2(MAX_PER_SLOT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSlot,
    StRead,
    StWrite,
    StRelease
  } state_e;

  state_e            state_q, state_d;
  logic signed [2:0] net_q [N_CNT];
  logic signed [2:0] net_d [N_CNT];
  logic [IdxW-1:0]   sel_q, sel_d;
  logic              dir_q, dir_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [SrvW-1:0]   srv_q, srv_d;
  logic [DW-1:0]     data_q, data_d;
  logic              armed_q, armed_d;
  logic              drop_q, drop_d;

  logic signed [3:0] base_s [N_CNT];
  logic signed [3:0] req_s  [N_CNT];
  logic signed [3:0] sum_s  [N_CNT];
  logic              any_d;
  logic [IdxW-1:0]   first_d;
  logic              wrapped;
  logic              more_ok;

  // Write credit is taken before the new request is applied, so a request arriving in the write
  // cycle of a saturated cell still fits.
  always_comb begin
    drop_d = 1'b0;
    for (int i = 0; i < int'(N_CNT); i++) begin
      base_s[i] = {net_q[i][2], net_q[i]};
      if (state_q == StWrite && sel_q == IdxW'(i)) begin
        if (base_s[i] > 4'sd0) begin
          base_s[i] = base_s[i] - 4'sd1;
        end else if (base_s[i] < 4'sd0) begin
          base_s[i] = base_s[i] + 4'sd1;
        end
      end
      if (inc_req[i] && !dec_req[i]) begin
        req_s[i] = 4'sd1;
      end else if (dec_req[i] && !inc_req[i]) begin
        req_s[i] = -4'sd1;
      end else begin
        req_s[i] = 4'sd0;
      end
      sum_s[i] = base_s[i] + req_s[i];
      if (sum_s[i] > 4'sd3 || sum_s[i] < -4'sd3) begin
        net_d[i] = base_s[i][2:0];
        drop_d   = 1'b1;
      end else begin
        net_d[i] = sum_s[i][2:0];
      end
    end
  end

  // Lowest pending cell wins.
  always_comb begin
    any_d   = 1'b0;
    first_d = '0;
    for (int i = int'(N_CNT) - 1; i >= 0; i--) begin
      if (net_d[i] != 3'sd0) begin
        any_d   = 1'b1;
        first_d = IdxW'(i);
      end
    end
  end

  always_comb begin
    wrapped = dir_q ? (&data_q) : ~(|data_q);
    more_ok = (32'(srv_q) + 32'd1) < MAX_PER_SLOT;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    lat_d     = lat_q;
    srv_d     = srv_q;
    data_d    = data_q;
    hold      = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    ovf       = '0;

    unique case (state_q)
      StIdle: begin
        if (any_d && armed_q) begin
          state_d = StWaitSlot;
        end
      end
      StWaitSlot: begin
        hold = 1'b1;
        if (slot_ok) begin
          if (any_d) begin
            state_d = StRead;
            sel_d   = first_d;
            dir_d   = net_d[first_d] > 3'sd0;
            lat_d   = '0;
            srv_d   = '0;
          end else begin
            // Pending work cancelled while waiting; nothing to do in this slot.
            state_d = StIdle;
          end
        end
      end
      StRead: begin
        hold     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = AW'(BASE_ADDR) + AW'(sel_q);
        if (32'(lat_q) == MEM_LAT) begin
          data_d  = mem_rdata;
          state_d = StWrite;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StWrite: begin
        hold       = 1'b1;
        mem_req    = 1'b1;
        mem_addr   = AW'(BASE_ADDR) + AW'(sel_q);
        mem_wr     = 1'b1;
        mem_wdata  = dir_q ? (data_q + DW'(1)) : (data_q - DW'(1));
        ovf[sel_q] = wrapped;
        if (more_ok && any_d) begin
          state_d = StRead;
          sel_d   = first_d;
          dir_d   = net_d[first_d] > 3'sd0;
          lat_d   = '0;
          srv_d   = srv_q + SrvW'(1);
        end else begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // armed guarantees the sequencer executes at least one instruction between slots.
  always_comb begin
    if (state_q == StRelease) begin
      armed_d = 1'b0;
    end else if (!slot_ok) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  assign drop = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      lat_q   <= '0;
      srv_q   <= '0;
      data_q  <= '0;
      armed_q <= 1'b1;
      drop_q  <= 1'b0;
      for (int i = 0; i < int'(N_CNT); i++) begin
        net_q[i] <= 3'sd0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      lat_q   <= lat_d;
      srv_q   <= srv_d;
      data_q  <= data_d;
      armed_q <= armed_d;
      drop_q  <= drop_d;
      for (int i = 0; i < int'(N_CNT); i++) begin
        net_q[i] <= net_d[i];
      end
    end
  end

endmodule

// File: tb/tb_counter_increment_sched.sv
// Scoreboard bench for counter_increment_sched: two instances (2 and 1 updates per slot), each
// with a registered-read memory model; expected writes are queued when requests are driven.
module tb_counter_increment_sched;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
    logic [7:0]  ovf;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  inc_a, dec_a, inc_b, dec_b;
  logic        slot_ok_a = 1'b1;
  logic        slot_ok_b;
  logic        hold_a, hold_b, mem_req_a, mem_req_b, mem_wr_a, mem_wr_b, drop_a, drop_b;
  logic [11:0] addr_a, addr_b;
  logic [15:0] rdata_a, rdata_b, wdata_a, wdata_b;
  logic [7:0]  ovf_a, ovf_b;

  logic        pk_we, pk_sel;
  logic [5:0]  pk_addr;
  logic [15:0] pk_data;
  logic [15:0] mem_a [64];
  logic [15:0] mem_b [64];

  bit   tied_a;
  int   n_checks, n_fail;
  int   wr_cnt_a, wr_cnt_b, drop_cnt_a, slot_cnt_a, bad_ovf;
  logic req_prev_a = 1'b0;
  wr_t  q_a[$];
  wr_t  q_b[$];

  counter_increment_sched #(.MAX_PER_SLOT(2)) u_dut_a (
    .clk(clk), .rst(rst), .inc_req(inc_a), .dec_req(dec_a), .slot_ok(slot_ok_a),
    .hold(hold_a), .mem_req(mem_req_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .mem_wdata(wdata_a), .mem_wr(mem_wr_a), .ovf(ovf_a), .drop(drop_a)
  );

  counter_increment_sched #(.MAX_PER_SLOT(1)) u_dut_b (
    .clk(clk), .rst(rst), .inc_req(inc_b), .dec_req(dec_b), .slot_ok(slot_ok_b),
    .hold(hold_b), .mem_req(mem_req_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .mem_wdata(wdata_b), .mem_wr(mem_wr_b), .ovf(ovf_b), .drop(drop_b)
  );

  always @(posedge clk) begin
    rdata_a <= mem_a[addr_a[5:0]];
    rdata_b <= mem_b[addr_b[5:0]];
    if (pk_we && !pk_sel) mem_a[pk_addr] <= pk_data;
    else if (mem_wr_a)    mem_a[addr_a[5:0]] <= wdata_a;
    if (pk_we && pk_sel)  mem_b[pk_addr] <= pk_data;
    else if (mem_wr_b)    mem_b[addr_b[5:0]] <= wdata_b;
  end

  // Sequencer model: parks with slot_ok=1 while held, otherwise runs instructions (toggles).
  always @(negedge clk) begin
    if (tied_a || hold_a) slot_ok_a <= 1'b1;
    else                  slot_ok_a <= ~slot_ok_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_a) begin
        wr_t e;
        wr_cnt_a++;
        check("a_write_expected", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          check("a_wr_addr", 32'(addr_a), 32'(e.addr));
          check("a_wr_data", 32'(wdata_a), 32'(e.data));
          check("a_wr_ovf", 32'(ovf_a), 32'(e.ovf));
        end
      end else if (ovf_a != 8'h00) begin
        bad_ovf++;
      end
      if (mem_wr_b) begin
        wr_t e;
        wr_cnt_b++;
        check("b_write_expected", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          check("b_wr_addr", 32'(addr_b), 32'(e.addr));
          check("b_wr_data", 32'(wdata_b), 32'(e.data));
        end
      end
      if (drop_a) drop_cnt_a++;
      if (mem_req_a && !req_prev_a) slot_cnt_a++;
      req_prev_a = mem_req_a;
    end
  end

  task automatic poke(input logic sel, input int a, input logic [15:0] d);
    pk_we = 1'b1; pk_sel = sel; pk_addr = 6'(a); pk_data = d;
    @(negedge clk);
    pk_we = 1'b0;
  endtask

  task automatic pulse_a(input logic [7:0] inc, input logic [7:0] dec);
    inc_a = inc; dec_a = dec;
    @(negedge clk);
    inc_a = '0; dec_a = '0;
  endtask

  task automatic wait_wr(input logic sel, input int target, input int budget, input string tag);
    for (int i = 0; i < budget && (sel ? wr_cnt_b : wr_cnt_a) < target; i++) @(negedge clk);
    check(tag, 32'(sel ? wr_cnt_b : wr_cnt_a), 32'(target));
  endtask

  initial begin
    int act, w0, d0, s0;
    rst = 1'b1; inc_a = '0; dec_a = '0; inc_b = '0; dec_b = '0;
    slot_ok_b = 1'b1; tied_a = 1'b1; pk_we = 1'b0; pk_sel = 1'b0; pk_addr = '0; pk_data = '0;
    repeat (2) @(negedge clk);
    poke(1'b0, 20, 16'd5);
    poke(1'b0, 21, 16'd100);
    poke(1'b0, 23, 16'hFFFF);
    poke(1'b0, 24, 16'h0000);
    poke(1'b0, 25, 16'd42);
    poke(1'b1, 21, 16'd7);
    poke(1'b1, 23, 16'd9);

    check("rst_hold", 32'(hold_a), 32'd0);
    check("rst_mem_req", 32'(mem_req_a), 32'd0);
    check("rst_mem_wr", 32'(mem_wr_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_drop", 32'(drop_a), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_wdata", 32'(wdata_a), 32'd0);
    check("rst_hold_b", 32'(hold_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single increment, slot_ok tied high
    q_a.push_back('{addr: 12'd20, data: 16'd6, ovf: 8'h00});
    pulse_a(8'h01, 8'h00);
    check("t1_hold_next_cycle", 32'(hold_a), 32'd1);
    @(negedge clk);
    check("t1_read_req", 32'(mem_req_a), 32'd1);
    check("t1_read_addr", 32'(addr_a), 32'd20);
    repeat (2) @(negedge clk);
    check("t1_wr_latency", 32'(mem_wr_a), 32'd1);
    @(negedge clk);
    check("t1_release_hold", 32'(hold_a), 32'd0);
    check("t1_release_req", 32'(mem_req_a), 32'd0);

    // inc and dec on the same cell cancel
    tied_a = 1'b0;
    repeat (4) @(negedge clk);
    w0 = wr_cnt_a;
    pulse_a(8'h04, 8'h04);
    act = 0;
    repeat (20) begin
      if (hold_a || mem_req_a || mem_wr_a) act++;
      @(negedge clk);
    end
    check("t2_cancel_activity", 32'(act), 32'd0);
    check("t2_cancel_writes", 32'(wr_cnt_a), 32'(w0));

    // Four back-to-back increments: one dropped, 2+1 writes across two slots
    q_a.push_back('{addr: 12'd21, data: 16'd101, ovf: 8'h00});
    q_a.push_back('{addr: 12'd21, data: 16'd102, ovf: 8'h00});
    q_a.push_back('{addr: 12'd21, data: 16'd103, ovf: 8'h00});
    w0 = wr_cnt_a; d0 = drop_cnt_a; s0 = slot_cnt_a;
    inc_a = 8'h02;
    repeat (4) @(negedge clk);
    inc_a = '0;
    wait_wr(1'b0, w0 + 3, 200, "t3_write_count");
    repeat (10) @(negedge clk);
    check("t3_write_count_settled", 32'(wr_cnt_a), 32'(w0 + 3));
    check("t3_drop_pulses", 32'(drop_cnt_a - d0), 32'd1);
    check("t3_slots", 32'(slot_cnt_a - s0), 32'd2);

    // Wrap in both directions
    q_a.push_back('{addr: 12'd23, data: 16'h0000, ovf: 8'h08});
    q_a.push_back('{addr: 12'd24, data: 16'hFFFF, ovf: 8'h10});
    w0 = wr_cnt_a;
    pulse_a(8'h08, 8'h10);
    wait_wr(1'b0, w0 + 2, 200, "t4_write_count");
    check("t4_ovf_outside_write", 32'(bad_ovf), 32'd0);

    // Reset one cycle before the write aborts it
    repeat (4) @(negedge clk);
    tied_a = 1'b1;
    @(negedge clk);
    w0 = wr_cnt_a;
    pulse_a(8'h20, 8'h00);
    for (int i = 0; i < 20 && !mem_req_a; i++) @(negedge clk);
    check("t6_reach_read", 32'(mem_req_a), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_no_write", 32'(mem_wr_a), 32'd0);
    check("t6_hold", 32'(hold_a), 32'd0);
    check("t6_mem_req", 32'(mem_req_a), 32'd0);
    check("t6_addr", 32'(addr_a), 32'd0);
    check("t6_wdata", 32'(wdata_a), 32'd0);
    check("t6_ovf_drop", 32'({ovf_a, drop_a}), 32'd0);
    rst = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (hold_a || mem_req_a) act++;
    end
    check("t6_pending_cleared", 32'(act), 32'd0);
    check("t6_write_count", 32'(wr_cnt_a), 32'(w0));
    q_a.push_back('{addr: 12'd25, data: 16'd43, ovf: 8'h00});
    pulse_a(8'h20, 8'h00);
    wait_wr(1'b0, w0 + 1, 50, "t6_after_reset_write");

    // One update per slot: cell 1 first, cell 3 only after slot_ok goes low then high
    q_b.push_back('{addr: 12'd21, data: 16'd8, ovf: 8'h00});
    q_b.push_back('{addr: 12'd23, data: 16'd10, ovf: 8'h00});
    inc_b = 8'h0A;
    @(negedge clk);
    inc_b = '0;
    wait_wr(1'b1, 1, 50, "t5_first_slot");
    repeat (20) @(negedge clk);
    check("t5_parked_writes", 32'(wr_cnt_b), 32'd1);
    check("t5_parked_hold", 32'(hold_b), 32'd0);
    slot_ok_b = 1'b0;
    @(negedge clk);
    slot_ok_b = 1'b1;
    wait_wr(1'b1, 2, 50, "t5_second_slot");

    repeat (5) @(negedge clk);
    check("end_queue_a", 32'(q_a.size()), 32'd0);
    check("end_queue_b", 32'(q_b.size()), 32'd0);
    check("end_bad_ovf", 32'(bad_ovf), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
